// File: rtl/crossbar_arbiter_ctrl_pkg.sv
// Crossbar arbiter controller: shared types and helpers.
// Holds the FSM state enum and the control-word packing function.
package crossbar_arbiter_ctrl_pkg;

    // Widest control word the packing helper can build.
    localparam int CW_MAX = 64;

    typedef enum logic [1:0] {
        IDLE,
        CONFIG,
        XFER,
        RELEASE
    } state_t;

    // Select width for an n-way choice; one bit minimum so that
    // single-entry configurations still get a legal vector.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Places input_sel in the top in_w bits and output_sel in the
    // out_w bits just below it; every other bit stays zero.
    function automatic logic [CW_MAX-1:0] pack_control(
        input int unsigned cw,
        input int unsigned in_w,
        input int unsigned out_w,
        input int unsigned in_sel,
        input int unsigned out_sel
    );
        logic [CW_MAX-1:0] w;
        w = (CW_MAX'(in_sel) << (cw - in_w))
          | (CW_MAX'(out_sel) << (cw - in_w - out_w));
        return w;
    endfunction

endpackage

// File: rtl/crossbar_arbiter_ctrl_rr_arbiter.sv
// N-way round-robin priority select starting at ptr (wrapping).
// Ports: req (request vector), ptr (first index to consider),
//        gnt_val (any request), gnt_idx (chosen index).
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_val,
    output logic [IW-1:0] gnt_idx
);

    // Scan from the farthest offset back to the pointer so the
    // last hit written is the nearest one at or after ptr.
    always_comb begin
        int j;
        j       = 0;
        gnt_val = 1'b0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt_val = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/crossbar_arbiter_ctrl.sv
// Crossbar arbiter controller: picks a requester, configures the
// crossbar, then holds the path open for one packet or until idle.
// Ports:
//   clk, reset (async active-low)
//   req_val[N], req_dest[N]      requester heads and destinations
//   control, control_val/_rdy    crossbar configuration handshake
//   xfer_fire                    one beat moved on the open path
//   grant_val, grant_idx         open path and its granted input
module crossbar_arbiter_ctrl
    import crossbar_arbiter_ctrl_pkg::*;
#(
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int CONTROL_BIT_WIDTH = 42,
    parameter int PKT_BEATS         = 4,
    parameter int TIMEOUT           = 255,
    localparam int IW = sel_w(N_INPUTS),
    localparam int OW = sel_w(N_OUTPUTS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_INPUTS-1:0]                 req_val,
    input  logic [N_INPUTS-1:0][OW-1:0]         req_dest,
    output logic [CONTROL_BIT_WIDTH-1:0]        control,
    output logic                                control_val,
    input  logic                                control_rdy,
    input  logic                                xfer_fire,
    output logic                                grant_val,
    output logic [IW-1:0]                       grant_idx
);

    localparam int CW   = CONTROL_BIT_WIDTH;
    localparam int CMAX = (PKT_BEATS > TIMEOUT) ? PKT_BEATS : TIMEOUT;
    localparam int CNTW = $clog2(CMAX + 1);

    localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(CMAX);
    localparam logic [CNTW-1:0] BEAT_LAST = CNTW'(PKT_BEATS - 1);
    localparam logic [CNTW-1:0] IDLE_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(N_INPUTS - 1);

    state_t          state;
    state_t          state_nx;
    logic            load;
    logic            arb_val;
    logic [IW-1:0]   arb_idx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   ctrl_q;
    logic [CNTW-1:0] beat_cnt;
    logic [CNTW-1:0] idle_cnt;
    logic            beat_done;
    logic            idle_done;

    rr_arbiter #(
        .N  (N_INPUTS),
        .IW (IW)
    ) u_arb (
        .req     (req_val),
        .ptr     (ptr),
        .gnt_val (arb_val),
        .gnt_idx (arb_idx)
    );

    // "This fire/idle cycle is the one that reaches the limit".
    assign beat_done = (beat_cnt == BEAT_LAST);
    assign idle_done = (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_val) begin
                    state_nx = CONFIG;
                    load     = 1'b1;
                end
            end
            CONFIG: begin
                if (control_rdy) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (xfer_fire ? beat_done : idle_done) begin
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            idx      <= '0;
            ctrl_q   <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            if (load) begin
                idx    <= arb_idx;
                ctrl_q <= CW'(pack_control(
                    CW, IW, OW,
                    int'(arb_idx),
                    int'(req_dest[arb_idx])));
            end
            // Counters only move while the path is open.
            if (state == XFER) begin
                if (xfer_fire) begin
                    idle_cnt <= '0;
                    if (beat_cnt != CNT_MAX) begin
                        beat_cnt <= beat_cnt + CNTW'(1);
                    end
                end else if (idle_cnt != CNT_MAX) begin
                    idle_cnt <= idle_cnt + CNTW'(1);
                end
                if (state_nx == RELEASE) begin
                    ctrl_q <= '0;
                end
            end
            if (state == RELEASE) begin
                ptr      <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
                beat_cnt <= '0;
                idle_cnt <= '0;
            end
        end
    end

    assign control     = ctrl_q;
    assign control_val = (state == CONFIG);
    assign grant_val   = (state == XFER);
    assign grant_idx   = idx;

endmodule

// File: tb/tb_crossbar_arbiter_ctrl.sv
// Testbench for crossbar_arbiter_ctrl (4 in, 4 out, 8-bit control,
// 3-beat packets, timeout 5): reference model plus directed vectors.
module tb_crossbar_arbiter_ctrl;

    logic            clk;
    logic            reset;
    logic [3:0]      req_val;
    logic [3:0][1:0] req_dest;
    logic [7:0]      control;
    logic            control_val;
    logic            control_rdy;
    logic            xfer_fire;
    logic            grant_val;
    logic [1:0]      grant_idx;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    crossbar_arbiter_ctrl #(
        .N_INPUTS          (4),
        .N_OUTPUTS         (4),
        .CONTROL_BIT_WIDTH (8),
        .PKT_BEATS         (3),
        .TIMEOUT           (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_dest    (req_dest),
        .control     (control),
        .control_val (control_val),
        .control_rdy (control_rdy),
        .xfer_fire   (xfer_fire),
        .grant_val   (grant_val),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 waiting, 1 configuring, 2 open,
    // 3 closing. Tracks the packet-level facts the outputs derive from.
    int m_phase = 0;
    int m_gnt   = 0;
    int m_dest  = 0;
    int m_beats = 0;
    int m_idle  = 0;
    int m_ptr   = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_gnt = 0; m_dest = 0;
            m_beats = 0; m_idle = 0; m_ptr = 0;
        end else begin
            case (m_phase)
                0: begin
                    for (int k = 3; k >= 0; k--) begin
                        if (req_val[(m_ptr + k) % 4]) begin
                            m_gnt  = (m_ptr + k) % 4;
                            m_dest = int'(req_dest[m_gnt]);
                            m_phase = 1;
                        end
                    end
                end
                1: if (control_rdy) m_phase = 2;
                2: begin
                    if (xfer_fire) begin
                        m_beats++;
                        m_idle = 0;
                        if (m_beats == 3) m_phase = 3;
                    end else begin
                        m_idle++;
                        if (m_idle == 5) m_phase = 3;
                    end
                end
                default: begin
                    m_ptr   = (m_gnt + 1) % 4;
                    m_beats = 0;
                    m_idle  = 0;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset) begin
            chk("model control_val", 32'(control_val), 32'(m_phase == 1));
            chk("model grant_val", 32'(grant_val), 32'(m_phase == 2));
            chk("model grant_idx", 32'(grant_idx), 32'(m_gnt));
            chk("model control", 32'(control),
                (m_phase == 1 || m_phase == 2) ?
                32'(m_gnt * 64 + m_dest * 16) : 32'd0);
        end
    end

    task automatic wait_cfg(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!control_val && n < 20);
        if (!control_val) chk({name, " wait timeout"}, 0, 1);
    endtask

    // Called at the CONFIG negedge with control_rdy already 1.
    task automatic finish_pkt();
        @(negedge clk);
        xfer_fire = 1'b1;
        repeat (3) @(negedge clk);
        xfer_fire = 1'b0;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset       = 1'b0;
        req_val     = '0;
        req_dest    = '0;
        control_rdy = 1'b0;
        xfer_fire   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset control", 32'(control), 0);
        chk("reset control_val", 32'(control_val), 0);
        chk("reset grant_val", 32'(grant_val), 0);
        chk("reset grant_idx", 32'(grant_idx), 0);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Single request: input 2 to output 3.
        req_val = 4'b0100; req_dest[2] = 2'd3; control_rdy = 1'b1;
        @(negedge clk);
        chk("single control_val", 32'(control_val), 1);
        chk("single control", 32'(control), 32'hB0);
        req_val = '0;
        @(negedge clk);
        chk("single grant_val", 32'(grant_val), 1);
        chk("single grant_idx", 32'(grant_idx), 2);
        xfer_fire = 1'b1;
        repeat (2) @(negedge clk);
        chk("single open after 2", 32'(grant_val), 1);
        @(negedge clk);
        chk("single release", 32'(grant_val), 0);
        xfer_fire = 1'b0;
        @(negedge clk);
        chk("single idle cv", 32'(control_val), 0);

        // Stray fires in IDLE and CONFIG; pointer is 3 here.
        xfer_fire = 1'b1;
        repeat (2) @(negedge clk);
        req_val = 4'b0001; req_dest[0] = 2'd1; control_rdy = 1'b0;
        @(negedge clk);
        chk("stray control", 32'(control), 32'h10);
        req_val = '0;
        @(negedge clk);
        chk("stray still config", 32'(control_val), 1);
        xfer_fire = 1'b0; control_rdy = 1'b1;
        @(negedge clk);
        chk("stray grant_val", 32'(grant_val), 1);
        xfer_fire = 1'b1;
        repeat (2) @(negedge clk);
        chk("stray open after 2", 32'(grant_val), 1);
        @(negedge clk);
        chk("stray release", 32'(grant_val), 0);
        xfer_fire = 1'b0;

        // Backpressure: input 3 to output 2, rdy low 4 cycles.
        req_val = 4'b1000; req_dest[3] = 2'd2; control_rdy = 1'b0;
        wait_cfg("bp");
        req_val = '0;
        for (int i = 0; i < 4; i++) begin
            chk("bp control", 32'(control), 32'hE0);
            chk("bp no grant", 32'(grant_val), 0);
            if (i < 3) @(negedge clk);
        end
        control_rdy = 1'b1;
        finish_pkt();

        // Round robin: all inputs requesting, pointer is 0.
        req_val = 4'b1111;
        req_dest = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int g = 0; g < 5; g++) begin
            wait_cfg("rr");
            chk("rr order", 32'(grant_idx), 32'(exp_order[g]));
            if (g == 4) req_val = '0;
            finish_pkt();
        end

        // Timeout: input 1 opened, no fires; pointer is 1.
        req_val = 4'b0010; req_dest[1] = 2'd0;
        wait_cfg("to");
        chk("to control", 32'(control), 32'h40);
        req_val = '0;
        @(negedge clk);
        chk("to open", 32'(grant_val), 1);
        repeat (4) @(negedge clk);
        chk("to open after 4 idle", 32'(grant_val), 1);
        @(negedge clk);
        chk("to release", 32'(grant_val), 0);
        req_val = 4'b1111;
        wait_cfg("to ptr");
        chk("to pointer 2", 32'(grant_idx), 2);
        req_val = '0;
        finish_pkt();

        // Reset mid-XFER; pointer is 3 here.
        req_val = 4'b1000; req_dest[3] = 2'd1;
        wait_cfg("rst");
        req_val = '0;
        @(negedge clk);
        xfer_fire = 1'b1;
        @(negedge clk);
        xfer_fire = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("rst control", 32'(control), 0);
        chk("rst control_val", 32'(control_val), 0);
        chk("rst grant_val", 32'(grant_val), 0);
        chk("rst grant_idx", 32'(grant_idx), 0);
        @(negedge clk);
        reset = 1'b1;
        req_val = 4'b1001; req_dest[0] = 2'd2;
        wait_cfg("rst re");
        chk("rst pointer 0", 32'(grant_idx), 0);
        chk("rst re control", 32'(control), 32'h20);
        req_val = '0;
        finish_pkt();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crossbar_arbiter_ctrl.md
CROSSBAR_ARBITER_CTRL -- requirements
Module: crossbar_arbiter_ctrl

Interface
REQ-001 The block SHALL have parameter N_INPUTS, default 2, meaning the number of crossbar inputs (requesters).
REQ-002 The block SHALL have parameter N_OUTPUTS, default 2, meaning the number of crossbar outputs.
REQ-003 The block SHALL have parameter CONTROL_BIT_WIDTH, default 42, meaning the width of the crossbar control word.
REQ-004 The block SHALL have parameter PKT_BEATS, default 4, meaning the number of beats per packet (>=1).
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning the number of idle cycles in XFER before the grant is revoked (>=1).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port req_val, input, [N_INPUTS]: input i has a packet head waiting.
REQ-009 The block SHALL have port req_dest, input, [N_INPUTS] x clog2(N_OUTPUTS): destination output of input i, valid while req_val[i] is high.
REQ-010 The block SHALL have port control, output, CONTROL_BIT_WIDTH: the crossbar configuration word.
REQ-011 The block SHALL have port control_val, output, 1 bit: control word valid.
REQ-012 The block SHALL have port control_rdy, input, 1 bit: the crossbar accepts the control word.
REQ-013 The block SHALL have port xfer_fire, input, 1 bit: one beat moved through the crossbar this cycle (granted input val & rdy).
REQ-014 The block SHALL have port grant_val, output, 1 bit: a path is configured and open.
REQ-015 The block SHALL have port grant_idx, output, clog2(N_INPUTS): the currently granted input.

Function
REQ-016 The block SHALL implement FSM states IDLE, CONFIG, XFER and RELEASE.
REQ-017 IDLE SHALL pick the lowest-indexed req_val[i] at or after the round-robin pointer (wrapping), latch i and req_dest[i], and go to CONFIG in the next cycle; with no requests it SHALL stay in IDLE.
REQ-018 The control word SHALL carry input_sel in bits [CW-1 : CW-clog2(N_INPUTS)] and output_sel in the next clog2(N_OUTPUTS) bits down, with all other bits 0.
REQ-019 In CONFIG, control_val SHALL be 1 with a stable control word until the cycle control_rdy=1, then the FSM SHALL go to XFER.
REQ-020 In XFER, grant_val SHALL be 1, and a beat counter SHALL increment on each xfer_fire; on the fire that brings the count to PKT_BEATS, the FSM SHALL go to RELEASE.
REQ-021 In XFER, an idle counter SHALL reset on xfer_fire and increment otherwise; reaching TIMEOUT SHALL go to RELEASE (abort).
REQ-022 RELEASE SHALL last exactly one cycle, set the round-robin pointer to (granted+1) mod N_INPUTS, clear the counters and return to IDLE.
REQ-023 xfer_fire SHALL be ignored outside XFER; req_val changes SHALL be ignored outside IDLE.
REQ-024 A newly arriving request SHALL not preempt an active grant; arbitration occurs only in IDLE.
REQ-025 Minimum turnaround SHALL be request seen -> control_val on the next cycle; back-to-back packets SHALL see a 1-cycle RELEASE gap.
REQ-026 The counters SHALL be sized to clog2(max(PKT_BEATS,TIMEOUT)+1) and SHALL not wrap.

Reset
REQ-027 On reset=0, the FSM SHALL asynchronously enter IDLE, with the pointer=0, counters=0, control=0, control_val=0, grant_val=0 and grant_idx=0.
REQ-028 Reset asserted mid-CONFIG or mid-XFER SHALL abort immediately, with no RELEASE and no pointer advance.

Structure
REQ-029 The shared package SHALL hold the FSM state enum and a function packing (input_sel, output_sel) into the control word.
REQ-030 The block SHALL use one sub-module, rr_arbiter (N-way round-robin priority select with pointer input); the rest SHALL stay inline.

Verification
(Bench parameters: N_INPUTS=4, N_OUTPUTS=4, CONTROL_BIT_WIDTH=8, PKT_BEATS=3, TIMEOUT=5.)
REQ-031 The bench SHALL cover a single request: req_val=0b0100, dest=3, control_rdy=1 -> control=0xB0 the next cycle, then grant_val, 3 fires -> RELEASE -> IDLE.
REQ-032 The bench SHALL cover round-robin: all 4 inputs requesting continuously -> grants in order 0,1,2,3,0.
REQ-033 The bench SHALL cover backpressure: control_rdy=0 for 4 cycles -> control_val held with control stable, XFER entered only after rdy=1.
REQ-034 The bench SHALL cover timeout: grant to input 1 followed by 5 cycles with no fire -> RELEASE, pointer=2.
REQ-035 The bench SHALL cover reset mid-XFER: after 1 fire, reset=0 -> all outputs 0 at once, pointer=0, and a subsequent request from input 0 granted first.
REQ-036 The bench SHALL cover stray fires: xfer_fire pulsed in IDLE/CONFIG -> no counter change, and the packet still needs 3 fires in XFER.
